// File: rtl/wb_drain_queue.sv
// wb_drain_queue: in-order writeback queue draining into a register bank, with youngest-match forwarding
// Ports: clk, rst (async active-low) | in_valid/in_ready/in_rd/in_data: producer request
//        we_o/rd_o/wr_data_o: register-bank write (head entry) | hold: suspend draining
//        rs1/rs2 -> fwd1_hit/fwd1_data, fwd2_hit/fwd2_data: forwarding lookups | count: pending entries
module wb_drain_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_rd,
    input  logic [31:0]              in_data,
    output logic                     we_o,
    output logic [4:0]               rd_o,
    output logic [31:0]              wr_data_o,
    input  logic                     hold,
    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    output logic                     fwd1_hit,
    output logic                     fwd2_hit,
    output logic [31:0]              fwd1_data,
    output logic [31:0]              fwd2_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    rd_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          push;
    logic          have;

    assign in_ready  = rst && (count < CW'(DEPTH));
    assign have      = rst && (count != '0);
    assign we_o      = have && !hold;
    assign push      = in_valid && in_ready && (in_rd != 5'd0);
    assign rd_o      = have ? rd_q[head] : 5'd0;
    assign wr_data_o = have ? data_q[head] : 32'd0;

    // DEPTH is a power of two, so pointer wrap is plain overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (we_o) head <= head + 1'b1;
            count <= count + CW'(push) - CW'(we_o);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[tail]   <= in_rd;
            data_q[tail] <= in_data;
        end
    end

    // Walk oldest to youngest so a later match overrides an earlier one
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = 32'd0;
        fwd2_hit  = 1'b0;
        fwd2_data = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count && rs1 != 5'd0 && rd_q[head + AW'(i)] == rs1) begin
                fwd1_hit  = 1'b1;
                fwd1_data = data_q[head + AW'(i)];
            end
            if (CW'(i) < count && rs2 != 5'd0 && rd_q[head + AW'(i)] == rs2) begin
                fwd2_hit  = 1'b1;
                fwd2_data = data_q[head + AW'(i)];
            end
        end
    end
endmodule
